// File: rtl/lo_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lo_sweep_ctrl                                                   |
// | Purpose  : Steps an LO phase increment across NUM_STEPS frequency points.  |
// |            At each point it waits SETTLE_CYCLES clocks, averages           |
// |            2^AVG_LOG2 demodulator samples and offers the result over a     |
// |            valid/ready handshake.                                          |
// | Ports    : clk, reset_n (async, active low)                                |
// |            start, abort           - sweep control                          |
// |            phi_start, phi_step    - first increment / increment per step   |
// |            phi_inc_o, lo_clken    - LO drive                               |
// |            demod_clk, demod_out   - sample strobe (rising edge) and data   |
// |            res_valid/res_ready, res_phi, res_avg - result handshake        |
// |            busy, done             - status (done = 1-cycle end pulse)      |
// | Options  : SWEEP_ABS_EN - accumulate |demod_out|, -131072 -> +131071      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lo_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 64,
   parameter int AVG_LOG2      = 4,
   parameter int NUM_STEPS     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        phi_start,
   input  logic [31:0]        phi_step,
   output logic [31:0]        phi_inc_o,
   output logic               lo_clken,
   input  logic               demod_clk,
   input  logic signed [17:0] demod_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [31:0]        res_phi,
   output logic signed [17:0] res_avg,
   output logic               busy,
   output logic               done
);

   localparam int ACC_W = 18 + AVG_LOG2;
   localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SMP_W = AVG_LOG2 + 1;

   localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'((1 << AVG_LOG2) - 1);
   localparam logic [15:0]      STEP_LAST   = 16'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      ACCUM  = 3'd2,
      EMIT   = 3'd3,
      FINISH = 3'd4
   } state_t;

   // A zero settle time skips SETTLE entirely after every retune.
   localparam state_t RETUNE_STATE = (SETTLE_CYCLES == 0) ? ACCUM : SETTLE;

   state_t                  state, state_n;
   logic                    demod_q;
   logic                    rise;
   logic signed [17:0]      sample;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic [SC_W-1:0]         settle_cnt;
   logic [SMP_W-1:0]        smp_cnt;
   logic [15:0]             step_cnt;
   logic [31:0]             phi_step_q;

   assign rise = demod_clk & ~demod_q;

`ifdef SWEEP_ABS_EN
   // -131072 has no positive 18-bit counterpart, so it clamps to +131071.
   always_comb begin
      if (demod_out == 18'sh20000)
         sample = 18'sd131071;
      else if (demod_out < 0)
         sample = -demod_out;
      else
         sample = demod_out;
   end
`else
   assign sample = demod_out;
`endif

   // Sign-extended add; ACC_W leaves AVG_LOG2 guard bits so no overflow.
   assign acc_sum = acc + ACC_W'(sample);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      busy      = (state != IDLE);
      lo_clken  = (state != IDLE);
      res_valid = (state == EMIT);
      done      = (state == FINISH);
      case (state)
         IDLE:    if (start && !abort) state_n = RETUNE_STATE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_n = ACCUM;
         ACCUM:   if (rise && (smp_cnt == SMP_LAST)) state_n = EMIT;
         EMIT:    if (res_ready) state_n = (step_cnt == STEP_LAST) ? FINISH : RETUNE_STATE;
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (abort && (state != IDLE))
         state_n = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         demod_q    <= 1'b0;
         phi_inc_o  <= '0;
         phi_step_q <= '0;
         res_phi    <= '0;
         res_avg    <= '0;
         acc        <= '0;
         smp_cnt    <= '0;
         settle_cnt <= '0;
         step_cnt   <= '0;
      end else begin
         demod_q <= demod_clk;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  phi_inc_o  <= phi_start;
                  phi_step_q <= phi_step;
                  step_cnt   <= '0;
                  settle_cnt <= '0;
                  acc        <= '0;
                  smp_cnt    <= '0;
               end
            end
            SETTLE: settle_cnt <= settle_cnt + SC_W'(1);
            ACCUM: begin
               if (rise) begin
                  acc     <= acc_sum;
                  smp_cnt <= smp_cnt + SMP_W'(1);
                  if (smp_cnt == SMP_LAST) begin
                     // Arithmetic shift floors toward minus infinity.
                     res_avg <= 18'(acc_sum >>> AVG_LOG2);
                     res_phi <= phi_inc_o;
                  end
               end
            end
            EMIT: begin
               if (res_ready && !abort && (step_cnt != STEP_LAST)) begin
                  phi_inc_o  <= phi_inc_o + phi_step_q;
                  step_cnt   <= step_cnt + 16'd1;
                  settle_cnt <= '0;
                  acc        <= '0;
                  smp_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lo_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lo_sweep_ctrl                                                |
// | Purpose  : Self-checking bench for lo_sweep_ctrl. Random demod samples are |
// |            compared with a floor-division average model; the expected     |
// |            phase of step k is phi_start + k*phi_step (mod 2^32).           |
// | Options  : SWEEP_ABS_EN - model takes |sample| with +131071 clamp          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lo_sweep_ctrl;

   localparam int SETTLE = 8;
   localparam int AVG    = 4;
   localparam int NSTEPS = 4;
   localparam int NAVG   = 1 << AVG;

   logic               clk       = 1'b0;
   logic               reset_n   = 1'b0;
   logic               start     = 1'b0;
   logic               abort     = 1'b0;
   logic [31:0]        phi_start = '0;
   logic [31:0]        phi_step  = '0;
   logic               demod_clk = 1'b0;
   logic signed [17:0] demod_out = '0;
   logic               res_ready = 1'b0;
   logic [31:0]        phi_inc_o;
   logic               lo_clken;
   logic               res_valid;
   logic [31:0]        res_phi;
   logic signed [17:0] res_avg;
   logic               busy;
   logic               done;

   int n_cmp      = 0;
   int n_err      = 0;
   int done_count = 0;

   always #5 clk = ~clk;

   lo_sweep_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .AVG_LOG2      (AVG),
      .NUM_STEPS     (NSTEPS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .phi_start (phi_start),
      .phi_step  (phi_step),
      .phi_inc_o (phi_inc_o),
      .lo_clken  (lo_clken),
      .demod_clk (demod_clk),
      .demod_out (demod_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_phi   (res_phi),
      .res_avg   (res_avg),
      .busy      (busy),
      .done      (done)
   );

   always @(posedge clk) if (done === 1'b1) done_count <= done_count + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int model_val(input logic signed [17:0] v);
      int x;
      x = int'(v);
`ifdef SWEEP_ABS_EN
      if (x < 0) x = -x;
      if (x > 131071) x = 131071;
`endif
      return x;
   endfunction

   function automatic int floor_div(input int num, input int den);
      int q;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   // mode 0: full-range random, 1: 1000, 2: -3, 3: -131072, 4: small random
   function automatic logic signed [17:0] gen_sample(input int mode);
      int t;
      case (mode)
         1:       return 18'sd1000;
         2:       return -18'sd3;
         3:       return 18'sh20000;
         4: begin t = int'($urandom_range(200, 0)) - 100; return 18'(t); end
         default: return 18'($urandom);
      endcase
   endfunction

   // ---------------- sweep driver / checker ----------------
   task automatic run_sweep(input logic [31:0] phi0, input logic [31:0] step,
                            input int mode, input int stall_step,
                            input int abort_step, input bit poke_start);
      logic [31:0]        exp_phi;
      logic signed [17:0] exp_avg;
      logic signed [17:0] v;
      int                 sum;
      int                 wait_cyc;
      int                 done_before;
      bit                 stable_ok;
      done_before = done_count;
      phi_start = phi0;
      phi_step  = step;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      phi_start = $urandom;
      phi_step  = $urandom;
      n_cmp++;
      if (busy !== 1'b1 || lo_clken !== 1'b1 || phi_inc_o !== phi0) begin
         n_err++;
         $display("FAIL sweep_start: busy=%b clken=%b phi=%h, required 1 1 %h", busy, lo_clken, phi_inc_o, phi0);
      end
      for (int k = 0; k < NSTEPS; k++) begin
         exp_phi = phi0 + step * 32'(k);
         @(negedge clk);
         if (k == abort_step) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || res_valid !== 1'b0 || lo_clken !== 1'b0) begin
               n_err++;
               $display("FAIL abort_idle: busy=%b valid=%b clken=%b, required 0 0 0", busy, res_valid, lo_clken);
            end
            repeat (4) @(negedge clk);
            n_cmp++;
            if (done_count !== done_before) begin
               n_err++;
               $display("FAIL abort_no_done: done pulses %0d, required %0d", done_count, done_before);
            end
            return;
         end
         // Strobe during SETTLE must be ignored; a start here must be too.
         demod_clk = 1'b1;
         demod_out = gen_sample(mode);
         if (poke_start && k == 0) begin
            start     = 1'b1;
            phi_start = ~phi0;
         end
         @(negedge clk);
         demod_clk = 1'b0;
         start     = 1'b0;
         repeat (SETTLE) @(negedge clk);
         sum = 0;
         for (int i = 0; i < NAVG; i++) begin
            v = gen_sample(mode);
            sum += model_val(v);
            demod_clk = 1'b1;
            demod_out = v;
            @(negedge clk);
            demod_clk = 1'b0;
            demod_out = 18'($urandom);
            @(negedge clk);
         end
         exp_avg  = 18'(floor_div(sum, NAVG));
         wait_cyc = 0;
         while (res_valid !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
         end
         n_cmp++;
         if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL res_valid_timeout: step %0d valid=%b, required 1", k, res_valid);
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         n_cmp++;
         if (res_phi !== exp_phi || phi_inc_o !== exp_phi) begin
            n_err++;
            $display("FAIL res_phi: step %0d res_phi=%h phi_inc=%h, required %h", k, res_phi, phi_inc_o, exp_phi);
         end
         n_cmp++;
         if (res_avg !== exp_avg) begin
            n_err++;
            $display("FAIL res_avg: step %0d got %0d, required %0d", k, res_avg, exp_avg);
         end
         if (k == stall_step) begin
            stable_ok = 1'b1;
            for (int c = 0; c < 50; c++) begin
               demod_clk = ~demod_clk;
               demod_out = 18'($urandom);
               @(negedge clk);
               if (res_valid !== 1'b1 || res_avg !== exp_avg || res_phi !== exp_phi ||
                   phi_inc_o !== exp_phi || busy !== 1'b1)
                  stable_ok = 1'b0;
            end
            demod_clk = 1'b0;
            n_cmp++;
            if (!stable_ok) begin
               n_err++;
               $display("FAIL stall_stable: valid=%b avg=%0d phi=%h, required 1 %0d %h", res_valid, res_avg, res_phi, exp_avg, exp_phi);
            end
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         if (k < NSTEPS - 1) begin
            n_cmp++;
            if (phi_inc_o !== exp_phi + step || busy !== 1'b1 || res_valid !== 1'b0) begin
               n_err++;
               $display("FAIL retune: phi=%h busy=%b valid=%b, required %h 1 0", phi_inc_o, busy, res_valid, exp_phi + step);
            end
         end else begin
            n_cmp++;
            if (done !== 1'b1) begin
               n_err++;
               $display("FAIL done_pulse: done=%b, required 1", done);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || lo_clken !== 1'b0 || phi_inc_o !== exp_phi ||
                done_count !== done_before + 1) begin
               n_err++;
               $display("FAIL finish_idle: done=%b busy=%b clken=%b phi=%h pulses=%0d, required 0 0 0 %h %0d",
                        done, busy, lo_clken, phi_inc_o, done_count - done_before, exp_phi, 1);
            end
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (phi_inc_o !== 32'd0 || res_phi !== 32'd0 || res_avg !== 18'sd0) begin
         n_err++;
         $display("FAIL reset_data: phi=%h res_phi=%h avg=%0d, required 0 0 0", phi_inc_o, res_phi, res_avg);
      end
      n_cmp++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lo_clken !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: valid=%b busy=%b done=%b clken=%b, required 0 0 0 0", res_valid, busy, done, lo_clken);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_start_abort_idle();
      start     = 1'b1;
      abort     = 1'b1;
      phi_start = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || lo_clken !== 1'b0 || phi_inc_o !== 32'd0) begin
         n_err++;
         $display("FAIL start_with_abort: busy=%b clken=%b phi=%h, required 0 0 0", busy, lo_clken, phi_inc_o);
      end
   endtask

   task automatic test_sweep_scenario();
      run_sweep(32'd343597384, 32'd34359738, 1, -1, -1, 1'b0);
      run_sweep($urandom, $urandom, 2, -1, -1, 1'b0);
   endtask

   task automatic test_wrap();
      run_sweep(32'hFFFF_FFF0, 32'h0000_0020, 0, -1, -1, 1'b0);
   endtask

   task automatic test_stall();
      run_sweep($urandom, $urandom, 0, 1, -1, 1'b0);
   endtask

   task automatic test_abort();
      run_sweep($urandom, $urandom, 4, -1, 2, 1'b1);
      run_sweep($urandom, $urandom, 0, -1, -1, 1'b0);
   endtask

   task automatic test_reset_mid_sweep();
      int done_before;
      done_before = done_count;
      phi_start = $urandom;
      phi_step  = $urandom;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (SETTLE + 2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         demod_clk = 1'b1;
         demod_out = gen_sample(0);
         @(negedge clk);
         demod_clk = 1'b0;
         @(negedge clk);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || lo_clken !== 1'b0 || res_valid !== 1'b0 || phi_inc_o !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset: busy=%b clken=%b valid=%b phi=%h, required 0 0 0 0", busy, lo_clken, res_valid, phi_inc_o);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done_count !== done_before) begin
         n_err++;
         $display("FAIL reset_no_done: busy=%b pulses=%0d, required 0 %0d", busy, done_count, done_before);
      end
      run_sweep($urandom, $urandom, 4, -1, -1, 1'b0);
   endtask

   task automatic test_saturation();
      run_sweep($urandom, $urandom, 3, -1, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_sweep($urandom, $urandom, 0, -1, -1, 1'b0);
      run_sweep($urandom, $urandom, 4, 3, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_start_abort_idle();
      test_sweep_scenario();
      test_wrap();
      test_stall();
      test_abort();
      test_reset_mid_sweep();
      test_saturation();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
